cpu_reg_bank: RTL and testbench
===============================

CPU_REG_BANK -- requirements
Module: cpu_reg_bank

Interface
REQ-001 Parameter WIDTH, default 32: bits per channel register.
REQ-002 Parameter NCH, default 4: number of channel registers; SW = max(1, clog2(NCH)).
REQ-003 Parameter INC_STEP, default 4: increment amount for op INC.
REQ-004 Parameter TMO, default 16: memory-wait timeout, in cycles; legal range is at least 2.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 Sel  input  SW  channel select for Op and MemReq.
REQ-008 Op  input  2  channel command: 00 HOLD, 01 LOAD, 10 INC, 11 CLR.
REQ-009 Ds  input  WIDTH  load data for LOAD.
REQ-010 MemReq  input  1  starts a memory-fed load of channel Sel.
REQ-011 MemDs  input  WIDTH  memory read data, valid when MOC=1.
REQ-012 MOC  input  1  memory operation complete.
REQ-013 Busy  output  1  high while the memory load is pending.
REQ-014 Done  output  1  one-cycle pulse when the memory load completes.
REQ-015 TimeoutErr  output  1  sticky flag for a memory-wait timeout.
REQ-016 Qs  output  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].

Function
REQ-017 Op SHALL take effect on the CLK edge where it is sampled; Qs reflects the result one cycle later.
REQ-018 Op SHALL act on channel Sel only: HOLD keeps the value, LOAD writes Ds, CLR writes 0.
REQ-019 INC SHALL write Qs[Sel]+INC_STEP modulo 2^WIDTH; all-ones+1 wraps to 0 silently.
REQ-020 Sel >= NCH SHALL ignore Op and MemReq with no state change.
REQ-021 The memory FSM SHALL have two states, IDLE and WAIT.
REQ-022 IDLE: MemReq=1 (Sel valid) SHALL latch Sel as tgt, clear the wait counter, clear TimeoutErr and enter WAIT.
REQ-023 WAIT with MOC=1 SHALL load MemDs into Qs[tgt], pulse Done for one cycle and return to IDLE.
REQ-024 WAIT with MOC=0 SHALL increment the counter.
REQ-025 In WAIT, when the counter reaches TMO-1 with MOC=0, the block SHALL set TimeoutErr, return to IDLE and leave Qs[tgt] unchanged.
REQ-026 Busy SHALL be 1 exactly when the FSM is in WAIT; MemReq while Busy SHALL be ignored.
REQ-027 Op SHALL remain accepted during WAIT; on the same edge, a MOC load to tgt SHALL override any Op to tgt.
REQ-028 Op to other channels and the MOC load SHALL both take effect on the same edge.
REQ-029 MOC in IDLE SHALL be ignored.

Reset
REQ-030 RST=1 SHALL immediately force all Qs to 0, Done=0, TimeoutErr=0, Busy=0, FSM to IDLE and the counter to 0, independent of CLK.
REQ-031 RST asserted during WAIT SHALL abandon the pending load; no Done pulse follows.

Configuration
REQ-032 With macro CPU_REG_BANK_PARITY_EN defined, each channel SHALL store an even-parity bit on every write.
REQ-033 With CPU_REG_BANK_PARITY_EN defined, output ParErr[NCH] SHALL flag a combinational parity mismatch per channel.
REQ-034 With CPU_REG_BANK_PARITY_EN defined, input ParInj (1 bit) SHALL invert the stored parity bit of any write in the same cycle.
REQ-035 With CPU_REG_BANK_PARITY_EN defined, the reset parity value SHALL be 0.
REQ-036 Without CPU_REG_BANK_PARITY_EN, ParErr, ParInj and the parity storage SHALL be absent; all other behaviour is identical.

Structure
REQ-037 Package cpu_reg_pkg SHALL hold the Op encoding constants, the FSM state typedef and the parameter defaults.
REQ-038 Sub-module reg_chan SHALL implement one channel: WIDTH register, op decode, memory-load override and optional parity.
REQ-039 cpu_reg_bank SHALL instantiate reg_chan NCH times and own the FSM and counter.

Verification
REQ-040 Check LOAD/INC wrap: Sel=1, LOAD Ds=32'hFFFFFFFE, then INC -> Qs[1]=FFFFFFFE, then 00000002 (INC_STEP=4).
REQ-041 Check memory load: MemReq Sel=2, MOC=1 after 3 cycles with MemDs=32'hA5A5A5A5 -> Busy high for 3 cycles, Done pulses once, Qs[2]=A5A5A5A5.
REQ-042 Check timeout: MemReq Sel=0, MOC held 0 -> TimeoutErr=1 after TMO=16 cycles, Qs[0] unchanged; next MemReq clears TimeoutErr.
REQ-043 Check collision: during WAIT on tgt=3, LOAD Ds=1 to ch3 and MOC=1 with MemDs=7 on the same edge -> Qs[3]=7.
REQ-044 Check collision, other channel: during WAIT on tgt=3, a LOAD to ch0 on the MOC edge -> Qs[0] updates as well.
REQ-045 Check reset mid-WAIT: assert RST mid-WAIT -> all Qs=0, Busy=0 immediately, no Done.
REQ-046 Check parity (CPU_REG_BANK_PARITY_EN): LOAD with ParInj=1 -> ParErr[Sel]=1; a clean LOAD clears it.

Source files
------------

// File: rtl/cpu_reg_pkg.sv
// ============================================================================
// Module : cpu_reg_pkg
// Brief  : Shared op encodings, memory-FSM state type and parameter defaults
//          for the cpu_reg_bank channel register bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_reg_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NCH      = 4;
  localparam int DEF_INC_STEP = 4;
  localparam int DEF_TMO      = 16;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Select width never collapses to zero, even for a single channel
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_chan.sv
// ============================================================================
// Module : reg_chan
// Brief  : One channel register with op decode, memory-load override and
//          optional even-parity storage (macro CPU_REG_BANK_PARITY_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_chan
  import cpu_reg_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int INC_STEP = DEF_INC_STEP
)(
  input  logic             CLK,
  input  logic             RST,
  input  logic             op_en_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] ds_i,
  input  logic             mem_we_i,
  input  logic [WIDTH-1:0] mem_data_i,
`ifdef CPU_REG_BANK_PARITY_EN
  input  logic             par_inj_i,
  output logic             par_err_o,
`endif
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // The memory load has priority over any op aimed at this channel
  always_comb begin
    data_d = data_q;
    if (mem_we_i) begin
      data_d = mem_data_i;
    end else if (op_en_i) begin
      case (op_i)
        OP_LOAD: data_d = ds_i;
        OP_INC:  data_d = data_q + WIDTH'(INC_STEP);
        OP_CLR:  data_d = '0;
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

`ifdef CPU_REG_BANK_PARITY_EN
  logic par_q;
  logic wr_en;

  assign wr_en = mem_we_i | (op_en_i & (op_i != OP_HOLD));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_q <= 1'b0;
    end else if (wr_en) begin
      par_q <= (^data_d) ^ par_inj_i;
    end
  end

  assign par_err_o = (^data_q) ^ par_q;
`endif

endmodule

`default_nettype wire

// File: rtl/cpu_reg_bank.sv
// ============================================================================
// Module : cpu_reg_bank
// Brief  : NCH-channel register bank with per-channel ops and a memory-fed
//          load FSM with timeout. Optional parity via CPU_REG_BANK_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_reg_bank
  import cpu_reg_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NCH      = DEF_NCH,
  parameter  int INC_STEP = DEF_INC_STEP,
  parameter  int TMO      = DEF_TMO,
  localparam int SW       = sel_width(NCH)
)(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [SW-1:0]        Sel,
  input  logic [1:0]           Op,
  input  logic [WIDTH-1:0]     Ds,
  input  logic                 MemReq,
  input  logic [WIDTH-1:0]     MemDs,
  input  logic                 MOC,
  output logic                 Busy,
  output logic                 Done,
  output logic                 TimeoutErr,
`ifdef CPU_REG_BANK_PARITY_EN
  input  logic                 ParInj,
  output logic [NCH-1:0]       ParErr,
`endif
  output logic [NCH*WIDTH-1:0] Qs
);

  localparam int CW = $clog2(TMO);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [SW-1:0] tgt_q,   tgt_d;
  logic          done_q,  done_d;
  logic          terr_q,  terr_d;
  logic          sel_valid;
  logic          load_mem;

  // A power-of-two channel count makes every select value legal
  if (NCH == (1 << SW)) begin : g_sel_full
    assign sel_valid = 1'b1;
  end else begin : g_sel_part
    assign sel_valid = ({1'b0, Sel} < (SW+1)'(NCH));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    done_d   = 1'b0;
    terr_d   = terr_q;
    load_mem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemReq && sel_valid) begin
          tgt_d   = Sel;
          cnt_d   = '0;
          terr_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MOC) begin
          load_mem = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          terr_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy       = (state_q == ST_WAIT);
  assign Done       = done_q;
  assign TimeoutErr = terr_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic op_en;
    logic mem_we;

    assign op_en  = sel_valid && (Sel == SW'(i));
    assign mem_we = load_mem && (tgt_q == SW'(i));

    reg_chan #(
      .WIDTH    (WIDTH),
      .INC_STEP (INC_STEP)
    ) u_chan (
      .CLK        (CLK),
      .RST        (RST),
      .op_en_i    (op_en),
      .op_i       (Op),
      .ds_i       (Ds),
      .mem_we_i   (mem_we),
      .mem_data_i (MemDs),
`ifdef CPU_REG_BANK_PARITY_EN
      .par_inj_i  (ParInj),
      .par_err_o  (ParErr[i]),
`endif
      .q_o        (Qs[i*WIDTH +: WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_reg_bank.sv
// ============================================================================
// Module : tb_cpu_reg_bank
// Brief  : Self-checking bench for cpu_reg_bank against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_reg_bank;

  localparam int WIDTH    = 32;
  localparam int NCH      = 4;
  localparam int INC_STEP = 4;
  localparam int TMO      = 16;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [1:0]           Sel;
  logic [1:0]           Op;
  logic [WIDTH-1:0]     Ds;
  logic                 MemReq;
  logic [WIDTH-1:0]     MemDs;
  logic                 MOC;
  logic                 Busy;
  logic                 Done;
  logic                 TimeoutErr;
  logic [NCH*WIDTH-1:0] Qs;
`ifdef CPU_REG_BANK_PARITY_EN
  logic                 ParInj;
  logic [NCH-1:0]       ParErr;
`endif

  cpu_reg_bank #(
    .WIDTH    (WIDTH),
    .NCH      (NCH),
    .INC_STEP (INC_STEP),
    .TMO      (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Sel        (Sel),
    .Op         (Op),
    .Ds         (Ds),
    .MemReq     (MemReq),
    .MemDs      (MemDs),
    .MOC        (MOC),
    .Busy       (Busy),
    .Done       (Done),
    .TimeoutErr (TimeoutErr),
`ifdef CPU_REG_BANK_PARITY_EN
    .ParInj     (ParInj),
    .ParErr     (ParErr),
`endif
    .Qs         (Qs)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: channel values plus the pending-load bookkeeping
  logic [WIDTH-1:0] m_q [NCH];
  bit               m_busy;
  int               m_tgt;
  int               m_wait;
  bit               m_done;
  bit               m_terr;

  typedef struct {
    int               sel;
    logic [1:0]       op;
    logic [WIDTH-1:0] ds;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  vec_t vt [10];

  function automatic logic [WIDTH-1:0] chan(input int ch);
    return Qs[ch*WIDTH +: WIDTH];
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_q[i] = '0;
    m_busy = 0; m_tgt = 0; m_wait = 0; m_done = 0; m_terr = 0;
  endtask

  task automatic model_edge(input int sel, input logic [1:0] op, input logic [WIDTH-1:0] ds,
                            input bit req, input bit moc, input logic [WIDTH-1:0] mds);
    logic [WIDTH-1:0] nq [NCH];
    for (int i = 0; i < NCH; i++) nq[i] = m_q[i];
    if (sel < NCH) begin
      if (op == 2'b01) nq[sel] = ds;
      if (op == 2'b10) nq[sel] = m_q[sel] + INC_STEP;
      if (op == 2'b11) nq[sel] = '0;
    end
    m_done = 0;
    if (m_busy) begin
      if (moc) begin
        nq[m_tgt] = mds;
        m_done = 1;
        m_busy = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_terr = 1;
          m_busy = 0;
        end
      end
    end else if (req && sel < NCH) begin
      m_busy = 1; m_tgt = sel; m_wait = 0; m_terr = 0;
    end
    for (int i = 0; i < NCH; i++) m_q[i] = nq[i];
  endtask

  task automatic check_all();
    for (int i = 0; i < NCH; i++) chk($sformatf("Qs[%0d]", i), chan(i), m_q[i]);
    chk("Busy", {31'b0, Busy}, {31'b0, m_busy});
    chk("Done", {31'b0, Done}, {31'b0, m_done});
    chk("TimeoutErr", {31'b0, TimeoutErr}, {31'b0, m_terr});
  endtask

  // Entered and left at posedge+1, so inputs never move near an active edge
  task automatic step(input int sel, input logic [1:0] op, input logic [WIDTH-1:0] ds,
                      input bit req, input bit moc, input logic [WIDTH-1:0] mds);
    Sel = 2'(sel); Op = op; Ds = ds; MemReq = req; MOC = moc; MemDs = mds;
    @(posedge CLK);
    model_edge(sel, op, ds, req, moc, mds);
    #1;
    check_all();
  endtask

  task automatic idle(input bit moc, input logic [WIDTH-1:0] mds);
    step(0, 2'b00, '0, 1'b0, moc, mds);
  endtask

  initial begin
    int busy_cnt;
    int k;
    logic [WIDTH-1:0] q0_before;

    RST = 1'b1; Sel = '0; Op = '0; Ds = '0; MemReq = 1'b0; MemDs = '0; MOC = 1'b0;
`ifdef CPU_REG_BANK_PARITY_EN
    ParInj = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    RST = 1'b0;

    vt[0] = '{1, 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    vt[1] = '{1, 2'b10, 32'h0,         32'h0000_0002};
    vt[2] = '{1, 2'b10, 32'h0,         32'h0000_0006};
    vt[3] = '{1, 2'b11, 32'h0,         32'h0000_0000};
    vt[4] = '{0, 2'b01, 32'h1234_5678, 32'h1234_5678};
    vt[5] = '{0, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678};
    vt[6] = '{3, 2'b10, 32'h0,         32'h0000_0004};
    vt[7] = '{2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[8] = '{2, 2'b10, 32'h0,         32'h0000_0003};
    vt[9] = '{3, 2'b00, 32'h0,         32'h0000_0004};
    for (int i = 0; i < 10; i++) begin
      step(vt[i].sel, vt[i].op, vt[i].ds, 1'b0, 1'b0, '0);
      chk($sformatf("vec%0d", i), chan(vt[i].sel), vt[i].exp_q);
    end

    // Memory load: three busy cycles then a single Done pulse
    busy_cnt = 0;
    step(2, 2'b00, '0, 1'b1, 1'b0, '0);
    if (Busy) busy_cnt++;
    for (int i = 0; i < 2; i++) begin
      idle(1'b0, '0);
      if (Busy) busy_cnt++;
    end
    idle(1'b1, 32'hA5A5_A5A5);
    chk("memload_busy_cycles", busy_cnt, 3);
    chk("memload_done", {31'b0, Done}, 32'd1);
    chk("memload_q2", chan(2), 32'hA5A5_A5A5);
    idle(1'b0, '0);
    chk("memload_done_drop", {31'b0, Done}, 32'd0);

    // Timeout on channel 0, then a new request clears the flag
    q0_before = chan(0);
    step(0, 2'b00, '0, 1'b1, 1'b0, 32'h1111_1111);
    k = 1;
    while (k <= 40) begin
      idle(1'b0, 32'h2222_2222);
      if (TimeoutErr) break;
      k++;
    end
    chk("timeout_latency", k, TMO);
    chk("timeout_q0", chan(0), q0_before);
    chk("timeout_busy", {31'b0, Busy}, 32'd0);
    step(1, 2'b00, '0, 1'b1, 1'b0, '0);
    chk("timeout_clear", {31'b0, TimeoutErr}, 32'd0);
    idle(1'b1, 32'h0BAD_F00D);

    // Collision on the target channel: memory data wins
    step(3, 2'b00, '0, 1'b1, 1'b0, '0);
    idle(1'b0, '0);
    step(3, 2'b01, 32'h1, 1'b0, 1'b1, 32'h7);
    chk("collide_tgt", chan(3), 32'h7);
    // Other channel written on the completion edge as well
    step(3, 2'b00, '0, 1'b1, 1'b0, '0);
    step(0, 2'b01, 32'hCAFE, 1'b0, 1'b1, 32'h55);
    chk("collide_other_ch0", chan(0), 32'hCAFE);
    chk("collide_other_ch3", chan(3), 32'h55);

    // Reset in the middle of a wait takes effect without a clock edge
    step(1, 2'b00, '0, 1'b1, 1'b0, '0);
    idle(1'b0, '0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < NCH; i++) chk($sformatf("rst_async_q%0d", i), chan(i), 32'h0);
    chk("rst_async_busy", {31'b0, Busy}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 32'hFFFF_0000);
      chk("rst_no_done", {31'b0, Done}, 32'd0);
    end

`ifdef CPU_REG_BANK_PARITY_EN
    ParInj = 1'b1;
    step(1, 2'b01, 32'h0000_0013, 1'b0, 1'b0, '0);
    ParInj = 1'b0;
    chk("par_inj", {31'b0, ParErr[1]}, 32'd1);
    step(1, 2'b01, 32'h0000_0013, 1'b0, 1'b0, '0);
    chk("par_clean", {31'b0, ParErr[1]}, 32'd0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, NCH-1)), 2'($urandom), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
